mem_access_arbiter: RTL and testbench

- Sequences the MAR/MDR/RAM memory subsystem: drives MARin, MDRin, MDRread, W_sig and the 32-bit bus value for complete read and write transactions.
- Shares that one memory port between two requesters: port 0 (CPU control unit) and port 1 (I/O / DMA engine).
- Each transaction is a req/done handshake. The block sits between the requesters and the memory subsystem inputs.

---
 rtl/mem_access_arbiter_if.sv | 28 ++
 rtl/mem_access_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_access_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_arbiter_if.sv
// mem_access_arbiter_if: requester handshakes plus the MAR/MDR/RAM control and bus signals.
// The slave modport is the arbiter's view; master is the requesters and memory side.
interface mem_access_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              p0_req, p1_req;
    logic              p0_we, p1_we;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [DATA_W-1:0] p0_wdata, p1_wdata;
    logic              p0_gnt, p1_gnt;
    logic              p0_done, p1_done;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [DATA_W-1:0] mdr_data;
    logic [DATA_W-1:0] BusMuxOut;
    logic              MARin, MDRin, MDRread, W_sig;

    modport slave (
        input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata, mdr_data,
        output p0_gnt, p1_gnt, p0_done, p1_done, rdata, busy, BusMuxOut, MARin, MDRin, MDRread, W_sig
    );

    modport master (
        output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata, mdr_data,
        input  p0_gnt, p1_gnt, p0_done, p1_done, rdata, busy, BusMuxOut, MARin, MDRin, MDRread, W_sig
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: two-port arbiter sequencing MAR/MDR/RAM read and write transactions.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module mem_access_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int RD_WAIT = 1
) (
    input logic                  Clock,
    input logic                  Clear,
    mem_access_arbiter_if.slave  m_if
);
    typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRITE, RWAIT, RLOAD, DONE} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d, port_q, port_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, bus_q, bus_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              mar_q, mar_d, mdrin_q, mdrin_d, mdrrd_q, mdrrd_d, w_q, w_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d, done0_q, done0_d, done1_q, done1_d;
    logic              busy_q, busy_d;
    logic              any_req, win;

    assign any_req = m_if.p0_req | m_if.p1_req;

`ifdef MEM_ARB_RR_EN
    logic last_q;
    // On a tie the port that was not granted last wins.
    assign win = (m_if.p0_req && m_if.p1_req) ? ~last_q : ~m_if.p0_req;
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear)
            last_q <= 1'b1;
        else if (state_q == IDLE && any_req)
            last_q <= win;
    end
`else
    assign win = ~m_if.p0_req;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        port_d  = port_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (any_req) begin
                state_d = ADDR;
                port_d  = win;
                we_d    = win ? m_if.p1_we    : m_if.p0_we;
                addr_d  = win ? m_if.p1_addr  : m_if.p0_addr;
                wdata_d = win ? m_if.p1_wdata : m_if.p0_wdata;
            end
            ADDR: begin
                state_d = we_q ? WDATA : RWAIT;
                cnt_d   = 3'(RD_WAIT - 1);
            end
            WDATA:   state_d = WRITE;
            WRITE:   state_d = DONE;
            RWAIT: begin
                state_d = (cnt_q == '0) ? RLOAD : RWAIT;
                cnt_d   = cnt_q - 3'd1;
            end
            RLOAD:   state_d = DONE;
            default: state_d = IDLE;
        endcase
        // Outputs are decoded from the next state so they register in step with it.
        mar_d   = state_d == ADDR;
        mdrin_d = state_d == WDATA || state_d == RLOAD;
        mdrrd_d = state_d == RLOAD;
        w_d     = state_d == WRITE;
        busy_d  = state_d != IDLE;
        gnt0_d  = busy_d && !port_d;
        gnt1_d  = busy_d && port_d;
        done0_d = state_d == DONE && !port_d;
        done1_d = state_d == DONE && port_d;
        bus_d   = state_d == ADDR  ? DATA_W'(addr_d) :
                  state_d == WDATA ? wdata_d : '0;
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            port_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            bus_q   <= '0;
            mar_q   <= 1'b0;
            mdrin_q <= 1'b0;
            mdrrd_q <= 1'b0;
            w_q     <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
            mar_q   <= mar_d;
            mdrin_q <= mdrin_d;
            mdrrd_q <= mdrrd_d;
            w_q     <= w_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            busy_q  <= busy_d;
        end
    end

    assign m_if.BusMuxOut = bus_q;
    assign m_if.MARin     = mar_q;
    assign m_if.MDRin     = mdrin_q;
    assign m_if.MDRread   = mdrrd_q;
    assign m_if.W_sig     = w_q;
    assign m_if.p0_gnt    = gnt0_q;
    assign m_if.p1_gnt    = gnt1_q;
    assign m_if.p0_done   = done0_q;
    assign m_if.p1_done   = done1_q;
    assign m_if.busy      = busy_q;
    // MDR only holds the RAM word once the DONE cycle starts, so rdata passes it through.
    assign m_if.rdata     = (state_q == DONE && !we_q) ? m_if.mdr_data : '0;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed vectors for mem_access_arbiter with a MAR/MDR/RAM model.
// Instance a uses RD_WAIT=1, instance b uses RD_WAIT=3.
module tb_mem_access_arbiter;
    logic Clock = 1'b0;
    logic Clear = 1'b0;
    always #5 Clock = ~Clock;

    mem_access_arbiter_if #(.ADDR_W(9), .DATA_W(32)) ia ();
    mem_access_arbiter_if #(.ADDR_W(9), .DATA_W(32)) ib ();

    mem_access_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_WAIT(1)) dut_a (.Clock(Clock), .Clear(Clear), .m_if(ia));
    mem_access_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_WAIT(3)) dut_b (.Clock(Clock), .Clear(Clear), .m_if(ib));

    // Memory subsystem models: MAR, MDR, RAM with registered read address.
    logic [8:0]  mar_a = '0, ra_a = '0, mar_b = '0, ra_b = '0;
    logic [31:0] mdr_a = '0, mdr_b = '0;
    logic [31:0] mem_a [512];
    logic [31:0] mem_b [512];
    logic        pre_b = 1'b0;

    always @(posedge Clock) begin
        if (ia.MARin) mar_a <= ia.BusMuxOut[8:0];
        if (ia.MDRin) mdr_a <= ia.MDRread ? mem_a[ra_a] : ia.BusMuxOut;
        if (ia.W_sig) mem_a[mar_a] <= mdr_a;
        ra_a <= mar_a;
    end
    always @(posedge Clock) begin
        if (ib.MARin) mar_b <= ib.BusMuxOut[8:0];
        if (ib.MDRin) mdr_b <= ib.MDRread ? mem_b[ra_b] : ib.BusMuxOut;
        if (ib.W_sig) mem_b[mar_b] <= mdr_b;
        if (pre_b) mem_b[9'h1FF] <= 32'hA5A5A5A5;
        ra_b <= mar_b;
    end
    assign ia.mdr_data = mdr_a;
    assign ib.mdr_data = mdr_b;

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic set_req(input logic p, input logic we, input logic [8:0] a, input logic [31:0] d, input logic r);
        if (p) begin
            ia.p1_we = we; ia.p1_addr = a; ia.p1_wdata = d; ia.p1_req = r;
        end else begin
            ia.p0_we = we; ia.p0_addr = a; ia.p0_wdata = d; ia.p0_req = r;
        end
    endtask

    // Counts edges until port p's done is seen on instance a (0 = never within bound).
    task automatic wait_done(input logic p, output int lat, output logic [31:0] rd,
                             output int wcnt, output logic [8:0] wmar, output int gbad, output logic own_gnt);
        lat = 0; rd = '0; wcnt = 0; wmar = '0; gbad = 0; own_gnt = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (ia.W_sig) begin wcnt++; wmar = mar_a; end
            if (p ? ia.p0_gnt : ia.p1_gnt) gbad++;
            if (p ? ia.p1_done : ia.p0_done) begin
                lat = i; rd = ia.rdata; own_gnt = p ? ia.p1_gnt : ia.p0_gnt;
                break;
            end
        end
    endtask

    typedef struct {
        logic        p;
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    int          lat, wcnt, gbad, first, d0, d1, t_d0, t_g1, n, ml, mc, dl;
    logic [31:0] rd;
    logic [8:0]  wmar;
    logic        og, prev, g;
    logic [3:0]  order, exp_order;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 9'h005, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 9'h005, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 9'h1FF, 32'h0BADF00D, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 9'h1FF, 32'h0,        32'h0BADF00D};
        vecs[4] = '{1'b0, 1'b0, 9'h1FF, 32'h0,        32'h0BADF00D};
        vecs[5] = '{1'b1, 1'b1, 9'h000, 32'hFFFFFFFF, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 9'h000, 32'h0,        32'hFFFFFFFF};
        vecs[7] = '{1'b1, 1'b0, 9'h005, 32'h0,        32'hDEADBEEF};

        set_req(1'b0, 1'b0, '0, '0, 1'b0);
        set_req(1'b1, 1'b0, '0, '0, 1'b0);
        ib.p0_req = 1'b0; ib.p0_we = 1'b0; ib.p0_addr = '0; ib.p0_wdata = '0;
        ib.p1_req = 1'b0; ib.p1_we = 1'b0; ib.p1_addr = '0; ib.p1_wdata = '0;
        pre_b = 1'b1;
        cyc();
        pre_b = 1'b0;
        chk("reset_ctl", 32'({ia.busy, ia.p0_gnt, ia.p1_gnt, ia.p0_done, ia.p1_done,
                              ia.MARin, ia.MDRin, ia.MDRread, ia.W_sig}), 32'h0);
        chk("reset_bus", ia.BusMuxOut | ia.rdata, 32'h0);
        Clear = 1'b1;
        cyc();

        for (int k = 0; k < 8; k++) begin
            set_req(vecs[k].p, vecs[k].we, vecs[k].addr, vecs[k].wdata, 1'b1);
            wait_done(vecs[k].p, lat, rd, wcnt, wmar, gbad, og);
            set_req(vecs[k].p, 1'b0, '0, '0, 1'b0);
            chk($sformatf("v%0d_latency", k), 32'(lat), 32'd4);
            chk($sformatf("v%0d_rdata", k), rd, vecs[k].exp_rd);
            chk($sformatf("v%0d_wsig_cnt", k), 32'(wcnt), vecs[k].we ? 32'd1 : 32'd0);
            if (vecs[k].we) chk($sformatf("v%0d_wsig_mar", k), 32'(wmar), 32'(vecs[k].addr));
            chk($sformatf("v%0d_gnt", k), 32'({og, gbad != 0}), 32'b10);
            cyc();
            chk($sformatf("v%0d_after", k), 32'({ia.p0_done, ia.p1_done, ia.busy}), 32'h0);
        end

        // Simultaneous requests: p0 read wins, p1 write follows after one IDLE cycle.
        set_req(1'b0, 1'b0, 9'h010, 32'h0, 1'b1);
        set_req(1'b1, 1'b1, 9'h011, 32'h12345678, 1'b1);
        first = -1; d0 = 0; d1 = 0; t_d0 = 0; t_g1 = 0;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            if (first < 0 && ia.p0_gnt) first = 0;
            if (first < 0 && ia.p1_gnt) first = 1;
            if (ia.p1_gnt && t_g1 == 0) t_g1 = i;
            if (ia.p0_done) begin d0++; t_d0 = i; ia.p0_req = 1'b0; end
            if (ia.p1_done) begin d1++; ia.p1_req = 1'b0; end
        end
        chk("tie_first", 32'(first), 32'd0);
        chk("tie_done_cnt", 32'({d0[7:0], d1[7:0]}), 32'h0101);
        chk("tie_idle_gap", 32'(t_g1 - t_d0), 32'd2);
        chk("tie_write_mem", mem_a[9'h011], 32'h12345678);

        // Both ports hold req across four grants.
        set_req(1'b0, 1'b0, 9'h005, 32'h0, 1'b1);
        set_req(1'b1, 1'b0, 9'h011, 32'h0, 1'b1);
        n = 0; prev = 1'b0; order = '0;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            g = ia.p0_gnt | ia.p1_gnt;
            if (g && !prev && n < 4) begin
                order[n] = ia.p1_gnt;
                n++;
                if (n == 4) begin ia.p0_req = 1'b0; ia.p1_req = 1'b0; end
            end
            prev = g;
        end
`ifdef MEM_ARB_RR_EN
        exp_order = 4'b1010;
`else
        exp_order = 4'b0000;
`endif
        chk("hold_grant_cnt", 32'(n), 32'd4);
        chk("hold_order", 32'(order), 32'(exp_order));
        chk("hold_idle_end", 32'(ia.busy), 32'h0);

        // RD_WAIT=3 read of 0x1FF on instance b.
        ib.p0_we = 1'b0; ib.p0_addr = 9'h1FF; ib.p0_req = 1'b1;
        ml = 0; mc = 0; dl = 0; rd = '0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (ib.MDRin && ib.MDRread) begin mc++; ml = i; end
            if (ib.p0_done) begin dl = i; rd = ib.rdata; ib.p0_req = 1'b0; break; end
        end
        chk("rw3_mdrload_edge", 32'(ml), 32'd5);
        chk("rw3_mdrload_cnt", 32'(mc), 32'd1);
        chk("rw3_done_edge", 32'(dl), 32'd6);
        chk("rw3_rdata", rd, 32'hA5A5A5A5);

        // Clear pulsed during RWAIT, then the held request restarts.
        set_req(1'b1, 1'b0, 9'h005, 32'h0, 1'b1);
        cyc();
        cyc();
        chk("rwait_busy", 32'({ia.busy, ia.p1_gnt}), 32'b11);
        #2 Clear = 1'b0;
        #1;
        chk("clr_async_ctl", 32'({ia.busy, ia.p0_gnt, ia.p1_gnt, ia.p0_done, ia.p1_done,
                                  ia.MARin, ia.MDRin, ia.MDRread, ia.W_sig}), 32'h0);
        chk("clr_async_bus", ia.BusMuxOut | ia.rdata, 32'h0);
        cyc();
        chk("clr_no_done", 32'({ia.p0_done, ia.p1_done, ia.busy}), 32'h0);
        Clear = 1'b1;
        wait_done(1'b1, lat, rd, wcnt, wmar, gbad, og);
        set_req(1'b1, 1'b0, '0, '0, 1'b0);
        chk("clr_restart_lat", 32'(lat), 32'd4);
        chk("clr_restart_rdata", rd, 32'hDEADBEEF);
        cyc();

        // p1 drops req during WDATA; the write still completes.
        set_req(1'b1, 1'b1, 9'h020, 32'h55AA55AA, 1'b1);
        cyc();
        chk("drop_addr_bus", ia.BusMuxOut, 32'h00000020);
        cyc();
        chk("drop_wdata_ctl", 32'({ia.MDRin, ia.MDRread, ia.MARin}), 32'b100);
        chk("drop_wdata_bus", ia.BusMuxOut, 32'h55AA55AA);
        ia.p1_req = 1'b0;
        wait_done(1'b1, lat, rd, wcnt, wmar, gbad, og);
        chk("drop_done_lat", 32'(lat), 32'd2);
        chk("drop_wsig", 32'({wcnt[7:0], 7'h0, wmar}), {8'd1, 7'h0, 9'h020});
        cyc();
        chk("drop_after", 32'({ia.busy, ia.p1_done, ia.p1_gnt}), 32'h0);
        cyc();
        chk("drop_idle", 32'(ia.busy), 32'h0);
        chk("drop_mem", mem_a[9'h020], 32'h55AA55AA);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
